// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execution units/decode and the register-file write arbiter.
interface regfile_wb_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          alu_valid;
  logic [4:0]                    alu_addr;
  logic [31:0]                   alu_data;
  logic                          alu_ready;
  logic                          lsu_valid;
  logic [4:0]                    lsu_addr;
  logic [31:0]                   lsu_data;
  logic                          lsu_ready;
  logic                          issue_valid;
  logic [4:0]                    issue_addr;
  logic [31:0]                   pending;
  logic                          rf_we;
  logic [4:0]                    rf_addr;
  logic [31:0]                   rf_din;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output issue_valid, issue_addr,
    input  alu_ready, lsu_ready, pending,
    input  rf_we, rf_addr, rf_din, fifo_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  issue_valid, issue_addr,
    output alu_ready, lsu_ready, pending,
    output rf_we, rf_addr, rf_din, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges in-order ALU results with FIFO-buffered
// long-latency results onto one write port, tracks outstanding long-latency
// destinations, and bounds how long the FIFO head can be starved by the ALU.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_ALU,
    GRANT_FIFO
  } grant_t;

  logic [4:0]    q_addr [FIFO_DEPTH];
  logic [31:0]   q_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    starve;
  logic [31:0]   pend;
  logic [31:0]   pend_next;
  logic          rf_we_q;
  logic [4:0]    rf_addr_q;
  logic [31:0]   rf_din_q;
  grant_t        grant;
  logic          empty;
  logic          full;
  logic          force_fifo;
  logic          push;
  logic          pop;

  // Arbitration and handshake decode from pre-edge state.
  always_comb begin
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    force_fifo = (starve == 4'(STARVE_LIMIT)) && !empty;
    grant      = GRANT_IDLE;
    if (force_fifo)         grant = GRANT_FIFO;
    else if (bus.alu_valid) grant = GRANT_ALU;
    else if (!empty)        grant = GRANT_FIFO;
    // A full FIFO refuses pushes even while popping; addr 0 handshakes but is dropped.
    push = bus.lsu_valid && !rst && !full && (bus.lsu_addr != '0);
    pop  = (grant == GRANT_FIFO);
  end

  // Scoreboard update: pop clears, issue sets (set wins), r0 never pending.
  always_comb begin
    pend_next = pend;
    if (pop) pend_next[q_addr[rd_ptr]] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != '0)) pend_next[bus.issue_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.lsu_addr;
      q_data[wr_ptr] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Starvation counter: counts ALU wins over a waiting FIFO head, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (pop || empty) begin
      starve <= '0;
    end else if ((grant == GRANT_ALU) && (starve != 4'(STARVE_LIMIT))) begin
      starve <= starve + 4'd1;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if ((grant == GRANT_ALU) && (bus.alu_addr != '0)) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= bus.alu_addr;
        rf_din_q  <= bus.alu_data;
      end else if (grant == GRANT_FIFO) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= q_addr[rd_ptr];
        rf_din_q  <= q_data[rd_ptr];
      end
    end
  end

  assign bus.alu_ready  = !rst && !force_fifo;
  assign bus.lsu_ready  = !rst && !full;
  assign bus.pending    = pend;
  assign bus.fifo_count = count;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_din     = rf_din_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback arbiter feeding the single write port (addr/din/we) of the 32x32 register file.
- Merges two result sources into that port:
  - ALU path: in-order, one result per cycle.
  - Long-latency path: load/mul-div results, buffered in a small FIFO.
- Keeps a pending-register scoreboard that decode uses to stall on RAW/WAW hazards against outstanding long-latency results.
- Enforces a starvation limit so the FIFO always drains.

Parameters:
- FIFO_DEPTH, 4, long-latency result FIFO entries; power of 2, range 2..16.
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose to the ALU before it is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle; when low, the ALU holds valid/addr/data stable.
- lsu_valid  in  1  long-latency result offered.
- lsu_addr  in  5  long-latency destination register.
- lsu_data  in  32  long-latency result.
- lsu_ready  out  1  FIFO can accept; push occurs when lsu_valid && lsu_ready.
- issue_valid  in  1  decode issues a long-latency op this cycle.
- issue_addr  in  5  destination of the issued op.
- pending  out  32  scoreboard; bit r=1 means a long-latency write to r is outstanding.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_din  out  32  register-file write data.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_addr=0, rf_din=0.
  - FIFO empty (fifo_count=0), pending=0, starvation counter=0.
  - lsu_ready=0 and alu_ready=0 while rst is high.
  - Reset mid-operation discards all FIFO contents and pending bits.
- lsu_ready = !rst && (fifo_count < FIFO_DEPTH), computed from pre-edge count. A full FIFO refuses a push even in a cycle where it also pops.
- Push:
  - lsu_addr != 0: the entry is enqueued.
  - lsu_addr == 0: the transfer is accepted (handshake completes) but not enqueued.
- Arbitration, per cycle, using pre-edge state:
  - force = (starve_cnt == STARVE_LIMIT) && fifo non-empty.
  - If force: FIFO head wins; alu_ready=0.
  - Else if alu_valid: ALU wins; alu_ready=1.
  - Else if fifo non-empty: FIFO head wins; alu_ready=1 (no ALU transfer).
  - Else: idle; alu_ready=1.
  - ALU result with alu_addr==0: consumed with alu_ready=1 and rf_we=0, but it still occupies the slot (counts as an ALU win).
- Output timing:
  - rf_we/rf_addr/rf_din are registered. The winner in cycle N appears on the outputs during cycle N+1.
  - rf_we=0 on idle cycles; rf_addr/rf_din hold their last values.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Resets to 0 on any FIFO pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO latency: an entry pushed in cycle N is eligible to pop in cycle N+1 at the earliest. There is no push-to-pop bypass.
- Simultaneous push and pop on a non-full FIFO: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - Set: issue_valid && issue_addr != 0 sets pending[issue_addr] at the edge.
  - Clear: a FIFO pop clears pending[popped addr] at the same edge.
  - Same register set and cleared in one cycle: set wins.
  - ALU writes never touch pending.
  - pending[0] is always 0.
- Ordering: ALU and FIFO writes may interleave. Decode prevents hazards by stalling on pending; the arbiter performs no address comparison between the two paths.

Test Plan:
- Reset, then ALU (addr=5, data=0x11111111) every cycle with an empty FIFO -> rf_we=1, rf_addr=5, rf_din=0x11111111 one cycle later; alu_ready stays 1.
- issue addr=8, then push lsu (8, 0xDEADBEEF) with alu_valid=0 -> pending[8]=1 after issue; write of 8/0xDEADBEEF appears 2 cycles after the push; pending[8]=0 at the pop edge.
- FIFO holds 1 entry, ALU valid every cycle, STARVE_LIMIT=3 -> three ALU writes, then alu_ready=0 for one cycle while the FIFO entry is written; the ALU data is held and written next cycle; no result lost or duplicated.
- Push 4 entries with no pops -> fifo_count=4, lsu_ready=0; a 5th lsu_valid is not accepted; after one pop, lsu_ready=1 the following cycle; entries pop in push order; pointers wrap across 10 fill/drain cycles.
- ALU addr=0, and lsu push addr=0 -> rf_we=0 on those slots; lsu handshake completes with fifo_count unchanged; pending[0] stays 0 even with issue_addr=0.
- Assert rst mid-drain with 3 entries queued and pending bits set -> outputs immediately 0; after release fifo_count=0, pending=0, and no stale writes occur.
